// File: rtl/xbee_rx_frame_if.sv
// Byte-stream side of the XBee API-mode-1 receiver: serial input plus parsed frame outputs.
interface xbee_rx_frame_if;
   logic       RxIn;
   logic [7:0] Dout;
   logic       DValid;
   logic [7:0] FrameLen;
   logic       FrameDone;
   logic       FrameErr;
   logic       BusyFlag;

   modport master (
      output RxIn,
      input  Dout, DValid, FrameLen, FrameDone, FrameErr, BusyFlag
   );

   modport slave (
      input  RxIn,
      output Dout, DValid, FrameLen, FrameDone, FrameErr, BusyFlag
   );
endinterface

// File: rtl/xbee_rx_frame.sv
// 8N1 UART receiver feeding an XBee API-mode-1 frame parser (delimiter, length, data, checksum).
module xbee_rx_frame #(
   parameter int unsigned CLKS_PER_BIT = 5208,
   parameter int unsigned MAX_LEN      = 64
) (
   input logic            Clk,
   input logic            Reset,
   xbee_rx_frame_if.slave rx_if
);
   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {UIdle, UStart, UData, UStop} u_state_e;
   typedef enum logic [2:0] {PIdle, PLenH, PLenL, PData, PCsum} p_state_e;

   logic            sync1_q, rx_s;
   u_state_e        u_state_q, u_state_d;
   logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      shift_q, shift_d;
   logic            byte_rdy, frame_err_u;

   p_state_e        p_state_q, p_state_d;
   logic [7:0]      cnt_q, cnt_d, acc_q, acc_d, dout_q, dout_d, len_q, len_d;
   logic            dvalid_q, dvalid_d, done_q, done_d, err_q, err_d;
   logic [7:0]      csum;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q   <= 1'b1;
         rx_s      <= 1'b1;
         u_state_q <= UIdle;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         p_state_q <= PIdle;
         cnt_q     <= '0;
         acc_q     <= '0;
         dout_q    <= '0;
         len_q     <= '0;
         dvalid_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         sync1_q   <= rx_if.RxIn;
         rx_s      <= sync1_q;
         u_state_q <= u_state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         p_state_q <= p_state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         dout_q    <= dout_d;
         len_q     <= len_d;
         dvalid_q  <= dvalid_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // UART: byte_rdy / frame_err_u are combinational in the stop-bit sample cycle.
   always_comb begin
      u_state_d   = u_state_q;
      clk_cnt_d   = clk_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      byte_rdy    = 1'b0;
      frame_err_u = 1'b0;
      unique case (u_state_q)
         UIdle: begin
            if (!rx_s) begin
               u_state_d = UStart;
               clk_cnt_d = '0;
            end
         end
         UStart: begin
            if (clk_cnt_q == HalfLast) begin
               clk_cnt_d = '0;
               bit_cnt_d = '0;
               u_state_d = rx_s ? UIdle : UData;
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         UData: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d = '0;
               shift_d   = {rx_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) u_state_d = UStop;
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         UStop: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d   = '0;
               u_state_d   = UIdle;
               byte_rdy    = rx_s;
               frame_err_u = !rx_s;
            end else begin
               clk_cnt_d = clk_cnt_q + CntW'(1);
            end
         end
         default: u_state_d = UIdle;
      endcase
   end

   assign csum = acc_q + shift_q;

   always_comb begin
      p_state_d = p_state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      dout_d    = dout_q;
      len_d     = len_q;
      dvalid_d  = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      if (frame_err_u && p_state_q != PIdle) begin
         err_d     = 1'b1;
         p_state_d = PIdle;
      end else if (byte_rdy) begin
         unique case (p_state_q)
            PIdle: if (shift_q == 8'h7E) p_state_d = PLenH;
            PLenH: begin
               if (shift_q == 8'h00) begin
                  p_state_d = PLenL;
               end else begin
                  err_d     = 1'b1;
                  p_state_d = PIdle;
               end
            end
            PLenL: begin
               len_d = shift_q;
               if (shift_q == 8'h00 || 32'(shift_q) > MAX_LEN) begin
                  err_d     = 1'b1;
                  p_state_d = PIdle;
               end else begin
                  cnt_d     = shift_q;
                  acc_d     = '0;
                  p_state_d = PData;
               end
            end
            PData: begin
               dout_d   = shift_q;
               dvalid_d = 1'b1;
               acc_d    = csum;
               cnt_d    = cnt_q - 8'd1;
               if (cnt_q == 8'd1) p_state_d = PCsum;
            end
            PCsum: begin
               done_d    = (csum == 8'hFF);
               err_d     = (csum != 8'hFF);
               p_state_d = PIdle;
            end
            default: p_state_d = PIdle;
         endcase
      end
   end

   assign rx_if.Dout      = dout_q;
   assign rx_if.DValid    = dvalid_q;
   assign rx_if.FrameLen  = len_q;
   assign rx_if.FrameDone = done_q;
   assign rx_if.FrameErr  = err_q;
   assign rx_if.BusyFlag  = (p_state_q != PIdle);
endmodule

// File: tb/tb_xbee_rx_frame.sv
// Scoreboard bench: a scanning frame model queues expected strobes, a monitor pops and compares.
module tb_xbee_rx_frame;
   localparam int unsigned Cpb    = 16;
   localparam int unsigned MaxLen = 64;
   localparam logic [1:0]  KData  = 2'd0;
   localparam logic [1:0]  KDone  = 2'd1;
   localparam logic [1:0]  KErr   = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] val;
      logic [7:0] len;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   xbee_rx_frame_if bus ();

   xbee_rx_frame #(.CLKS_PER_BIT(Cpb), .MAX_LEN(MaxLen)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .rx_if (bus)
   );

   always #5 Clk = ~Clk;

   exp_t       exp_q[$];
   logic [7:0] seg_b[$];
   bit         seg_bad[$];
   logic [7:0] ref_len = 8'h00;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input logic [1:0] kind, input logic [7:0] val);
      exp_q.push_back(exp_t'{kind: kind, val: val, len: ref_len});
   endtask

   // Reference: scan the byte stream for frames and list the strobes each one must produce.
   task automatic model_segment();
      int         i = 0;
      int         n = seg_b.size();
      logic [7:0] sum;
      bit         aborted;
      while (i < n) begin
         if (seg_bad[i] || seg_b[i] != 8'h7E) begin i++; continue; end
         i++;
         if (i >= n) break;
         if (seg_bad[i] || seg_b[i] != 8'h00) begin push(KErr, 8'h00); i++; continue; end
         i++;
         if (i >= n) break;
         if (seg_bad[i]) begin push(KErr, 8'h00); i++; continue; end
         ref_len = seg_b[i];
         i++;
         if (ref_len == 0 || ref_len > MaxLen) begin push(KErr, 8'h00); continue; end
         sum = 8'h00;
         aborted = 1'b0;
         for (int k = 0; k < int'(ref_len) && i < n; k++) begin
            if (seg_bad[i]) begin push(KErr, 8'h00); aborted = 1'b1; i++; break; end
            push(KData, seg_b[i]);
            sum = sum + seg_b[i];
            i++;
         end
         if (aborted || i >= n) continue;
         if (seg_bad[i]) push(KErr, 8'h00);
         else if (8'(sum + seg_b[i]) == 8'hFF) push(KDone, 8'h00);
         else push(KErr, 8'h00);
         i++;
      end
   endtask

   task automatic add(input logic [7:0] b, input bit bad = 1'b0);
      seg_b.push_back(b);
      seg_bad.push_back(bad);
   endtask

   task automatic add_frame(input int len, input bit good_sum);
      logic [7:0] sum = 8'h00;
      logic [7:0] d;
      add(8'h7E); add(8'h00); add(8'(len));
      for (int k = 0; k < len; k++) begin
         d = 8'($urandom_range(0, 255));
         add(d);
         sum = sum + d;
      end
      add(good_sum ? 8'hFF - sum : 8'hFF - sum + 8'(1 + $urandom_range(0, 254)));
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      bus.RxIn = 1'b0;
      repeat (Cpb) @(negedge Clk);
      for (int k = 0; k < 8; k++) begin
         bus.RxIn = b[k];
         repeat (Cpb) @(negedge Clk);
      end
      // A low stop bit is released shortly after its sample point so it cannot fake a start bit.
      bus.RxIn = 1'b0;
      if (bad_stop) repeat (14) @(negedge Clk);
      bus.RxIn = 1'b1;
      repeat (Cpb + $urandom_range(2, 6)) @(negedge Clk);
   endtask

   task automatic run_segment(input string name);
      model_segment();
      for (int j = 0; j < seg_b.size(); j++) send_byte(seg_b[j], seg_bad[j]);
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge Clk);
      chk({name, "_drain"}, exp_q.size(), 0);
      chk({name, "_busy_idle"}, int'(bus.BusyFlag), 0);
      seg_b.delete();
      seg_bad.delete();
   endtask

   task automatic chk_reset(input string name);
      chk({name, "_dout"}, int'(bus.Dout), 0);
      chk({name, "_dvalid"}, int'(bus.DValid), 0);
      chk({name, "_len"}, int'(bus.FrameLen), 0);
      chk({name, "_done"}, int'(bus.FrameDone), 0);
      chk({name, "_err"}, int'(bus.FrameErr), 0);
      chk({name, "_busy"}, int'(bus.BusyFlag), 0);
   endtask

   // Monitor
   exp_t       mon_e;
   int         mon_n;
   logic [1:0] mon_kind;
   always @(negedge Clk) begin
      if (!Reset) begin
         mon_n = int'(bus.DValid) + int'(bus.FrameDone) + int'(bus.FrameErr);
         if (mon_n != 0) begin
            chk("strobe_exclusive", mon_n, 1);
            mon_kind = bus.DValid ? KData : (bus.FrameDone ? KDone : KErr);
            if (exp_q.size() == 0) begin
               chk("unexpected_strobe", int'(mon_kind), 3);
            end else begin
               mon_e = exp_q.pop_front();
               chk("strobe_kind", int'(mon_kind), int'(mon_e.kind));
               chk("frame_len", int'(bus.FrameLen), int'(mon_e.len));
               if (mon_e.kind == KData) chk("dout", int'(bus.Dout), int'(mon_e.val));
               else chk("busy_at_end", int'(bus.BusyFlag), 0);
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      int         sel;
      bus.RxIn = 1'b1;
      Reset    = 1'b1;
      #1;
      chk_reset("reset_async");
      repeat (4) @(negedge Clk);
      chk_reset("reset_held");
      Reset = 1'b0;
      repeat (4) @(negedge Clk);

      add(8'h7E); add(8'h00); add(8'h02); add(8'hCE); add(8'h31); add(8'h00);
      run_segment("good");
      add(8'h7E); add(8'h00); add(8'h02); add(8'hCE); add(8'h31); add(8'h01);
      run_segment("bad_sum");
      add(8'h7E); add(8'h00); add(8'h00);
      add(8'h7E); add(8'h00); add(8'h41);
      add(8'h7E); add(8'h01); add(8'h05);
      run_segment("bad_len");
      add(8'h55); add(8'hAA);
      add(8'h7E); add(8'h00); add(8'h02); add(8'hCE); add(8'h31); add(8'h00);
      run_segment("noise");

      bus.RxIn = 1'b0;
      repeat (3) @(negedge Clk);
      bus.RxIn = 1'b1;
      repeat (3 * Cpb) @(negedge Clk);
      chk("glitch_busy", int'(bus.BusyFlag), 0);

      add(8'h7E); add(8'h00); add(8'h03); add(8'h11); add(8'h22, 1'b1);
      add_frame(3, 1'b1);
      run_segment("framing");
      add_frame(MaxLen, 1'b1);
      run_segment("max_len");

      for (int f = 0; f < 12; f++) begin
         for (int k = $urandom_range(0, 2); k > 0; k--) begin
            do v = 8'($urandom_range(0, 255)); while (v == 8'h7E);
            add(v);
         end
         sel = $urandom_range(0, 9);
         if (sel <= 5) add_frame($urandom_range(1, 10), 1'b1);
         else if (sel <= 7) add_frame($urandom_range(1, 10), 1'b0);
         else if (sel == 8) begin
            add(8'h7E); add(8'h00);
            add($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MaxLen + 1, 255)));
         end else begin
            add(8'h7E); add(8'($urandom_range(1, 255))); add(8'h03);
         end
      end
      run_segment("random");

      send_byte(8'h7E, 1'b0);
      send_byte(8'h00, 1'b0);
      bus.RxIn = 1'b0;
      repeat (3 * Cpb) @(negedge Clk);
      Reset = 1'b1;
      #1;
      chk_reset("reset_mid");
      bus.RxIn = 1'b1;
      repeat (5) @(negedge Clk);
      Reset = 1'b0;
      ref_len = 8'h00;
      repeat (2 * Cpb) @(negedge Clk);
      chk("post_reset_busy", int'(bus.BusyFlag), 0);
      add(8'h7E); add(8'h00); add(8'h01); add(8'h7E); add(8'h81);
      run_segment("after_reset");

      repeat (10) @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/xbee_rx_frame.md
Name: xbee_rx_frame

Overview:
Downstream companion of the XBee transmit path: a serial receiver plus XBee API-mode-1 frame parser for the Nexys2 design. It deserialises an 8N1 UART stream (the line the transmitter drives as DoutTx, or the XBee module's DOUT pin). It strips the 0x7E delimiter and 16-bit length, presents frame-data bytes one per strobe, and checks the trailing checksum. Its output feeds on-chip consumers that need byte-level frame data with a per-frame good/bad verdict.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); the bench overrides it to 16.
MAX_LEN, 64, largest accepted frame-data length in bytes.

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  asynchronous, active-high reset
RxIn  input  1  serial line, idle high, 8N1, LSB first
Dout  output  8  current frame-data byte; holds last value
DValid  output  1  one-cycle strobe: Dout is a new frame-data byte
FrameLen  output  8  length field of current/last frame (LSB byte)
FrameDone  output  1  one-cycle strobe: frame complete, checksum good
FrameErr  output  1  one-cycle strobe: frame aborted or checksum bad
BusyFlag  output  1  high from accepted 0x7E until parser returns to IDLE

Behaviour:
- Reset (async, active-high) forces: Dout=0, DValid=0, FrameLen=0, FrameDone=0, FrameErr=0, BusyFlag=0.
- Reset also forces both FSMs to idle, clears the bit and byte counters and the checksum accumulator, and sets the synchroniser flops to 1.
- Reset mid-frame discards the partial frame and produces no strobe.
- RxIn passes through a 2-flop synchroniser before use.
- UART FSM states: U_IDLE, U_START, U_DATA, U_STOP.
  - U_IDLE: a synchronised low level moves the FSM to U_START.
  - U_START: the line is sampled after CLKS_PER_BIT/2 cycles. If high, this is a glitch and the FSM returns to U_IDLE. If low, it moves to U_DATA.
  - U_DATA: 8 samples are taken, each CLKS_PER_BIT cycles apart, shifting LSB first.
  - U_STOP: the line is sampled one bit period later. High: byte_rdy pulses for one cycle with the byte. Low: framing error; the byte is dropped and frame_err_u pulses.
  - After U_STOP the FSM returns to U_IDLE. No wait for the line to go high; U_IDLE only reacts to a low level.
- Frame FSM states: P_IDLE, P_LENH, P_LENL, P_DATA, P_CSUM. It advances only on byte_rdy.
  - P_IDLE: 0x7E moves to P_LENH and sets BusyFlag. Any other byte is ignored silently.
  - P_LENH: a nonzero byte causes abort. A zero byte moves to P_LENL.
  - P_LENL: FrameLen is latched. A value of 0 or greater than MAX_LEN causes abort. Otherwise the byte counter is loaded with the length, the accumulator is cleared, and the FSM moves to P_DATA.
  - P_DATA: each byte drives Dout, pulses DValid, adds into the 8-bit accumulator (modulo 256) and decrements the counter. When the counter reaches 0 the FSM moves to P_CSUM.
  - P_CSUM: if (accumulator + byte) mod 256 == 0xFF, FrameDone pulses. Otherwise FrameErr pulses. Either way the FSM returns to P_IDLE and BusyFlag drops.
  - Abort: FrameErr pulses for one cycle, the FSM returns to P_IDLE and BusyFlag drops.
- Latency: DValid, FrameDone and FrameErr rise exactly 1 cycle after the stop-bit sample cycle.
- 0x7E inside P_LENL, P_DATA or P_CSUM is ordinary data; there is no resync and no escaping (API mode 1).
- A framing error (frame_err_u) while BusyFlag=1 causes abort. While in P_IDLE it is ignored.
- DValid and FrameDone/FrameErr are never high in the same cycle. FrameDone and FrameErr are mutually exclusive.

Test Plan:
1. Good frame: CLKS_PER_BIT=16; send 7E 00 02 CE 31 00 → DValid twice with Dout=0xCE then 0x31; FrameLen=0x02; FrameDone pulses once; FrameErr stays 0; BusyFlag falls with FrameDone.
2. Bad checksum: send 7E 00 02 CE 31 01 → two DValid strobes, then FrameErr pulses once and FrameDone stays 0.
3. Bad lengths: 7E 00 00 → FrameErr with FrameLen=0x00. 7E 00 41 (MAX_LEN=64) → FrameErr. 7E 01 05 → FrameErr after the second byte. No DValid in any case.
4. Noise and glitch: bytes 55 AA before a good frame produce no strobes, then the frame completes as in case 1. A 3-cycle low glitch on idle RxIn produces no byte.
5. Framing error: in the middle of 7E 00 03 11 22 …, the second data byte is sent with stop bit 0 → FrameErr pulses, BusyFlag=0. A following good frame is received correctly.
6. Reset mid-frame: assert Reset during the third byte → all outputs 0 immediately with no strobe. After release, 7E 00 01 7E 81 → DValid with Dout=0x7E, then FrameDone.
